// File: rtl/sca_flip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sca_flip_sequencer
// Brief    : Serial-framed DUT stimulus sequencer that loads a base vector and
//            toggles one bit per cycle. Define SCA_FRAME_PARITY_EN to append
//            and check a trailing even-parity bit on every frame.
// Revision : 1.0 - initial release
// ============================================================================
module sca_flip_sequencer #(
  parameter int NUM_INS = 51,
  parameter int IDX_W   = 6,
  parameter int CNT_W   = 8,
  parameter int IDLE_TO = 1024
) (
  input  logic               flip_clk_i,
  input  logic               reset_i,
  input  logic               sca_data_i,
  input  logic               sca_clk_i,
  output logic [NUM_INS-1:0] dut_inputs_o,
  output logic               trigger_o,
  output logic               busy_o,
  output logic               pending_o,
  output logic               frame_err_o
);

`ifdef SCA_FRAME_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_LEN = IDX_W + CNT_W + NUM_INS + PAR_W;
  localparam int BC_W      = $clog2(FRAME_LEN);
  localparam int TO_W      = $clog2(IDLE_TO + 1);

  localparam logic [BC_W-1:0]    BC_LAST   = BC_W'(FRAME_LEN - 1);
  localparam logic [BC_W-1:0]    BC_ONE    = BC_W'(1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(IDLE_TO);
  localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W:0]     IDX_LIMIT = (IDX_W + 1)'(NUM_INS);
  localparam logic [NUM_INS-1:0] BIT0      = NUM_INS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [2:0]           sclk_sync_q;
  logic [1:0]           sdat_sync_q;
  logic [FRAME_LEN-2:0] shift_q;
  logic [BC_W-1:0]      bitcnt_q;
  logic [TO_W-1:0]      idle_q;
  logic                 frame_err_q;
  logic                 in_vld_q;
  logic [IDX_W-1:0]     in_idx_q;
  logic [CNT_W-1:0]     in_cnt_q;
  logic [NUM_INS-1:0]   in_base_q;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic [CNT_W-1:0]     cur_cnt_q, cur_cnt_d;
  logic [NUM_INS-1:0]   cur_base_q, cur_base_d;
  logic                 pend_q, pend_d;
  logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;
  logic [CNT_W-1:0]     pend_cnt_q, pend_cnt_d;
  logic [NUM_INS-1:0]   pend_base_q, pend_base_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;
  logic                 first_q, first_d;
  logic [NUM_INS-1:0]   dut_q, dut_d;
  logic                 trigger_q, trigger_d;
  logic                 busy_q, busy_d;

  logic                 w_fall;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_frame_done;
  logic                 w_timeout;
  logic [IDX_W-1:0]     w_f_idx;
  logic [CNT_W-1:0]     w_f_cnt;
  logic [NUM_INS-1:0]   w_f_base;
  logic                 w_par_bad;
  logic                 w_idx_bad;
  logic                 w_slot_free;
  logic                 w_pend_take;
  logic                 w_overrun;
  logic                 w_accept;
  logic [NUM_INS-1:0]   w_flip_mask;

  assign w_fall       = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign w_frame      = {shift_q, sdat_sync_q[1]};
  assign w_frame_done = w_fall & (bitcnt_q == BC_LAST);
  assign w_timeout    = ~w_fall & (idle_q == TO_LAST);

  assign w_f_idx  = w_frame[FRAME_LEN-1 -: IDX_W];
  assign w_f_cnt  = w_frame[PAR_W + NUM_INS +: CNT_W];
  assign w_f_base = w_frame[PAR_W +: NUM_INS];

`ifdef SCA_FRAME_PARITY_EN
  assign w_par_bad = ^w_frame;
`else
  assign w_par_bad = 1'b0;
`endif
  assign w_idx_bad = ({1'b0, w_f_idx} >= IDX_LIMIT);

  // A pending command being consumed this cycle frees the slot for the new frame
  assign w_slot_free = (state_q == ST_IDLE)
                     | ((state_q == ST_ARM) & (cur_cnt_q == '0))
                     | ((state_q == ST_RUN) & (tcnt_q == CNT_ONE));
  assign w_pend_take = w_slot_free & pend_q;
  assign w_overrun   = pend_q & ~w_pend_take;
  assign w_accept    = w_frame_done & ~w_par_bad & ~w_idx_bad & ~w_overrun;
  assign w_flip_mask = BIT0 << cur_idx_q;

  always_ff @(posedge flip_clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      idle_q      <= '0;
      frame_err_q <= 1'b0;
      in_vld_q    <= 1'b0;
      in_idx_q    <= '0;
      in_cnt_q    <= '0;
      in_base_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sca_clk_i};
      sdat_sync_q <= {sdat_sync_q[0], sca_data_i};
      frame_err_q <= w_timeout | (w_frame_done & ~w_accept);
      in_vld_q    <= w_accept;
      if (w_accept) begin
        in_idx_q  <= w_f_idx;
        in_cnt_q  <= w_f_cnt;
        in_base_q <= w_f_base;
      end
      if (w_fall) begin
        shift_q  <= w_frame[FRAME_LEN-2:0];
        bitcnt_q <= w_frame_done ? '0 : bitcnt_q + BC_ONE;
        idle_q   <= '0;
      end else if (w_timeout) begin
        bitcnt_q <= '0;
        idle_q   <= '0;
      end else if (bitcnt_q != '0) begin
        idle_q   <= idle_q + TO_ONE;
      end
    end
  end

  always_ff @(posedge flip_clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cur_idx_q   <= '0;
      cur_cnt_q   <= '0;
      cur_base_q  <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_cnt_q  <= '0;
      pend_base_q <= '0;
      tcnt_q      <= '0;
      first_q     <= 1'b0;
      dut_q       <= '0;
      trigger_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      cur_cnt_q   <= cur_cnt_d;
      cur_base_q  <= cur_base_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_base_q <= pend_base_d;
      tcnt_q      <= tcnt_d;
      first_q     <= first_d;
      dut_q       <= dut_d;
      trigger_q   <= trigger_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    cur_cnt_d   = cur_cnt_q;
    cur_base_d  = cur_base_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    pend_cnt_d  = pend_cnt_q;
    pend_base_d = pend_base_q;
    tcnt_d      = tcnt_q;
    first_d     = first_q;
    dut_d       = dut_q;
    trigger_d   = 1'b0;

    case (state_q)
      ST_ARM: begin
        dut_d   = cur_base_q;
        tcnt_d  = cur_cnt_q;
        first_d = 1'b1;
        state_d = (cur_cnt_q == '0) ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        dut_d     = dut_q ^ w_flip_mask;
        tcnt_d    = tcnt_q - CNT_ONE;
        first_d   = 1'b0;
        trigger_d = first_q;
        if (tcnt_q == CNT_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The older buffered command always wins over a freshly validated one
    if (w_slot_free & (pend_q | in_vld_q)) begin
      state_d = ST_ARM;
      if (pend_q) begin
        cur_idx_d   = pend_idx_q;
        cur_cnt_d   = pend_cnt_q;
        cur_base_d  = pend_base_q;
        pend_d      = in_vld_q;
        pend_idx_d  = in_idx_q;
        pend_cnt_d  = in_cnt_q;
        pend_base_d = in_base_q;
      end else begin
        cur_idx_d   = in_idx_q;
        cur_cnt_d   = in_cnt_q;
        cur_base_d  = in_base_q;
      end
    end else if (in_vld_q) begin
      pend_d      = 1'b1;
      pend_idx_d  = in_idx_q;
      pend_cnt_d  = in_cnt_q;
      pend_base_d = in_base_q;
    end

    busy_d = (state_d != ST_IDLE) | (state_q == ST_RUN);
  end

  assign dut_inputs_o = dut_q;
  assign trigger_o    = trigger_q;
  assign busy_o       = busy_q;
  assign pending_o    = pend_q;
  assign frame_err_o  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sca_flip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sca_flip_sequencer
// Brief    : Directed bench for sca_flip_sequencer (SCA_FRAME_PARITY_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sca_flip_sequencer;
  localparam int NUM_INS = 51;
  localparam int IDX_W   = 6;
  localparam int CNT_W   = 10;
  localparam int IDLE_TO = 1024;
  localparam int BODY    = IDX_W + CNT_W + NUM_INS;
`ifdef SCA_FRAME_PARITY_EN
  localparam int FL = BODY + 1;
`else
  localparam int FL = BODY;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               sca_data;
  logic               sca_clk;
  logic [NUM_INS-1:0] dut_inputs;
  logic               trigger;
  logic               busy;
  logic               pending;
  logic               frame_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sca_flip_sequencer #(
    .NUM_INS (NUM_INS),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W),
    .IDLE_TO (IDLE_TO)
  ) u_dut (
    .flip_clk_i   (clk),
    .reset_i      (reset),
    .sca_data_i   (sca_data),
    .sca_clk_i    (sca_clk),
    .dut_inputs_o (dut_inputs),
    .trigger_o    (trigger),
    .busy_o       (busy),
    .pending_o    (pending),
    .frame_err_o  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame MSB first and returns in the detection cycle D
  task automatic send_frame(input logic [IDX_W-1:0] idx, input logic [CNT_W-1:0] cnt,
                            input logic [NUM_INS-1:0] base, input int nbits,
                            input bit par_flip, output int d);
    logic [BODY-1:0] body;
    logic [FL-1:0]   f;
    body = {idx, cnt, base};
`ifdef SCA_FRAME_PARITY_EN
    f = {body, (^body) ^ par_flip};
`else
    f = body;
    if (par_flip) f[0] = ~f[0];
`endif
    for (int i = 0; i < nbits; i++) begin
      sca_data = f[FL-1-i];
      sca_clk  = 1'b1;
      tick(); tick(); tick();
      sca_clk  = 1'b0;
      if (i != nbits - 1) begin
        tick(); tick(); tick();
      end
    end
    tick(); tick();
    d = cyc;
  endtask

  localparam logic [NUM_INS-1:0] ONES   = '1;
  localparam logic [NUM_INS-1:0] BASE_V = 51'h2AAAA55551234;
  localparam logic [NUM_INS-1:0] BASE_T = 51'h7FFFF0000FFFF;
  localparam logic [NUM_INS-1:0] BASE_A = 51'h0123456789ABC;
  localparam logic [NUM_INS-1:0] BASE_B = 51'h00F0FF0F00F0F;
  localparam logic [NUM_INS-1:0] BIT5   = 51'h20;
  localparam logic [NUM_INS-1:0] BIT20  = 51'h100000;
  localparam logic [NUM_INS-1:0] BIT50  = 51'h4000000000000;

  initial begin
    int  d, da, db, dc, first_err, n_pulse;
    bit  seen_trig, seen_busy;
    logic [63:0] exp_dut;

    reset    = 1'b1;
    sca_clk  = 1'b1;
    sca_data = 1'b0;
    tick(); tick(); tick();
    check("rst_dut", dut_inputs, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rst_trigger", trigger, 0);
    check("rst_pending", pending, 0);
    check("rst_frame_err", frame_err, 0);

    // Basic command: index 5, count 4, base 0
    send_frame(6'd5, 10'd4, '0, FL, 1'b0, d);
    for (int k = 1; k <= 8; k++) begin
      goto(d + k);
      exp_dut = (k == 4 || k == 6) ? 64'(BIT5) : 64'd0;
      check($sformatf("basic_dut_D+%0d", k), dut_inputs, exp_dut);
      check($sformatf("basic_trig_D+%0d", k), trigger, (k == 4) ? 64'd1 : 64'd0);
      check($sformatf("basic_busy_D+%0d", k), busy, (k >= 2 && k <= 7) ? 64'd1 : 64'd0);
    end

    // Index out of range
    send_frame(6'd51, 10'd3, BASE_V, FL, 1'b0, d);
    goto(d + 1);
    check("badidx_err", frame_err, 1);
    goto(d + 2);
    check("badidx_err_clear", frame_err, 0);
    goto(d + 3);
    check("badidx_busy", busy, 0);
    check("badidx_dut", dut_inputs, 0);

    // Truncated frame aborted by idle timeout
    send_frame(6'd9, 10'd9, BASE_V, 20, 1'b0, d);
    first_err = -1;
    n_pulse   = 0;
    seen_busy = 0;
    for (int k = 1; k <= IDLE_TO + 6; k++) begin
      goto(d + k);
      if (frame_err) begin
        n_pulse++;
        if (first_err < 0) first_err = k;
      end
      if (busy) seen_busy = 1;
    end
    check("timeout_window", (first_err >= IDLE_TO && first_err <= IDLE_TO + 3), 1);
    check("timeout_pulses", n_pulse, 1);
    check("timeout_busy", seen_busy, 0);
    send_frame(6'd0, 10'd1, BASE_T, FL, 1'b0, d);
    goto(d + 3);
    check("after_to_base", dut_inputs, BASE_T);
    goto(d + 4);
    check("after_to_flip", dut_inputs, BASE_T ^ 51'h1);
    check("after_to_trig", trigger, 1);
    goto(d + 5);
    check("after_to_hold", dut_inputs, BASE_T ^ 51'h1);
    check("after_to_idle", busy, 0);

    // Buffering: A long run, B pended, C overruns
    send_frame(6'd10, 10'd1000, BASE_A, FL, 1'b0, da);
    send_frame(6'd50, 10'd3, BASE_B, FL, 1'b0, db);
    goto(db + 2);
    check("buf_pending", pending, 1);
    check("buf_busy", busy, 1);
    send_frame(6'd1, 10'd5, ONES, FL, 1'b0, dc);
    goto(dc + 1);
    check("buf_overrun_err", frame_err, 1);
    goto(dc + 2);
    check("buf_keep_pending", pending, 1);
    goto(da + 1002);
    check("buf_a_last_busy", busy, 1);
    goto(da + 1003);
    check("buf_a_final", dut_inputs, BASE_A);
    check("buf_pend_clear", pending, 0);
    goto(da + 1004);
    check("buf_b_base", dut_inputs, BASE_B);
    goto(da + 1005);
    check("buf_b_t1", dut_inputs, BASE_B ^ BIT50);
    check("buf_b_trig", trigger, 1);
    goto(da + 1006);
    check("buf_b_t2", dut_inputs, BASE_B);
    goto(da + 1008);
    check("buf_b_final", dut_inputs, BASE_B ^ BIT50);
    check("buf_b_idle", busy, 0);
    check("buf_c_dropped", pending, 0);

    // Zero count: base applied, no trigger
    send_frame(6'd7, 10'd0, ONES, FL, 1'b0, d);
    seen_trig = 0;
    for (int k = 1; k <= 8; k++) begin
      goto(d + k);
      if (trigger) seen_trig = 1;
    end
    check("zero_dut", dut_inputs, ONES);
    check("zero_trig", seen_trig, 0);
    check("zero_busy", busy, 0);

    // Reset in the middle of a run
    send_frame(6'd20, 10'd100, '0, FL, 1'b0, d);
    goto(d + 12);
    check("midrst_pre", dut_inputs, BIT20);
    reset = 1'b1;
    tick();
    check("midrst_dut", dut_inputs, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pending", pending, 0);
    reset = 1'b0;
    n_pulse = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (frame_err) n_pulse++;
    end
    check("midrst_no_err", n_pulse, 0);
    check("midrst_stays", dut_inputs, 0);

`ifdef SCA_FRAME_PARITY_EN
    send_frame(6'd3, 10'd2, BASE_V, FL, 1'b1, d);
    n_pulse   = 0;
    seen_busy = 0;
    for (int k = 1; k <= 5; k++) begin
      goto(d + k);
      if (frame_err) n_pulse++;
      if (busy) seen_busy = 1;
    end
    check("par_bad_pulses", n_pulse, 1);
    check("par_bad_busy", seen_busy, 0);
    send_frame(6'd3, 10'd2, BASE_V, FL, 1'b0, d);
    goto(d + 3);
    check("par_ok_base", dut_inputs, BASE_V);
    goto(d + 4);
    check("par_ok_flip", dut_inputs, BASE_V ^ 51'h8);
    check("par_ok_trig", trigger, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
